asic_sram_banked: RTL and testbench

ASIC_SRAM_BANKED -- requirements
Module: asic_sram_banked

---
 rtl/asic_sram_banked.sv | 188 ++++++++++++++++++
 tb/tb_asic_sram_banked.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/asic_sram_banked.sv
`default_nettype none
// ============================================================================
// Module   : asic_sram_banked
// Purpose  : Word-addressed SRAM split into NUM_BANKS independent arrays.
//            The low address bits select the bank and the upper bits the row.
//            Only the addressed bank is enabled on an access. After reset an
//            INIT sweep zeroes every word, one per cycle. Requests are refused
//            until the sweep is done. Reads return after RD_LAT cycles
//            (1 or 2). Writes use per-byte lane enables.
// Ports    : clk        in   clock, rising edge
//            rst_n      in   synchronous active-low reset
//            req_valid  in   request present
//            req_ready  out  request can be accepted (RUN state)
//            req_we     in   1 = write, 0 = read
//            req_addr   in   word address [ADDR_W]
//            req_be     in   byte-lane write enables [DATA_W/8]
//            req_wdata  in   write data [DATA_W]
//            rsp_valid  out  one-cycle read-data strobe
//            rsp_rdata  out  read data, held while rsp_valid=0
//            init_busy  out  clear sweep in progress
//            bank_act   out  one-hot enable of the bank accessed this cycle
// Revision : 1.0 - initial release
// ============================================================================
module asic_sram_banked #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 6,
  parameter int NUM_BANKS = 2,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W/8-1:0]    req_be,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   init_busy,
  output logic [NUM_BANKS-1:0]   bank_act
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = ADDR_W - BANK_BITS;
  localparam int ROWS      = 1 << ROW_W;
  localparam int LANES     = DATA_W / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  generate
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $error("asic_sram_banked: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8 != 0) || (DATA_W < 16)) begin : g_bad_data_w
      $error("asic_sram_banked: DATA_W must be a multiple of 8, at least 16");
    end
    if ((NUM_BANKS < 1) || ((1 << BANK_BITS) != NUM_BANKS) || (NUM_BANKS > (1 << (ADDR_W - 1)))) begin : g_bad_banks
      $error("asic_sram_banked: NUM_BANKS must be a power of 2 in 1..2^(ADDR_W-1)");
    end
  endgenerate

  logic [0:0]         r_state;
  logic [ADDR_W-1:0]  r_cnt;
  logic               w_run;
  logic               w_acc;
  logic               w_rd;
  logic               w_we;
  logic [LANES-1:0]   w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic [ADDR_W-1:0]  w_addr;
  logic [BANK_W-1:0]  w_bank;
  logic [ROW_W-1:0]   w_row;
  logic               r_v1;
  logic [BANK_W-1:0]  r_sel;
  logic [DATA_W-1:0]  w_q;
  logic [DATA_W-1:0]  w_bank_q [NUM_BANKS];

  assign w_run     = (r_state == ST_RUN);
  assign req_ready = w_run;
  assign init_busy = !w_run;

  // The INIT sweep borrows the same bank port as user requests: it is a
  // full-lane write of zero to the counter address.
  assign w_acc   = rst_n && (w_run ? req_valid : 1'b1);
  assign w_rd    = rst_n && w_run && req_valid && !req_we;
  assign w_we    = w_run ? req_we    : 1'b1;
  assign w_be    = w_run ? req_be    : {LANES{1'b1}};
  assign w_wdata = w_run ? req_wdata : {DATA_W{1'b0}};
  assign w_addr  = w_run ? req_addr  : r_cnt;
  assign w_row   = w_addr[ADDR_W-1 -: ROW_W];

  generate
    if (BANK_BITS > 0) begin : g_bank_dec
      assign w_bank = w_addr[BANK_W-1:0];
    end else begin : g_single_bank
      assign w_bank = '0;
    end
  endgenerate

  assign bank_act = w_acc ? (NUM_BANKS'(1) << w_bank) : '0;

  // INIT -> RUN on the edge that clears the last word; the counter wraps to
  // zero on that same edge and is only ever restarted by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (!w_run) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_state <= ST_RUN;
      end
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] mem [ROWS];
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk) begin
        if (bank_act[b] && w_we) begin
          for (int k = 0; k < LANES; k++) begin
            if (w_be[k]) begin
              mem[w_row][8*k +: 8] <= w_wdata[8*k +: 8];
            end
          end
        end
      end

      // Bank output register loads only on a read of this bank, so it holds
      // the last word read between reads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (bank_act[b] && !w_we) begin
          r_q <= mem[w_row];
        end
      end

      assign w_bank_q[b] = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_sel <= '0;
    end else begin
      r_v1 <= w_rd;
      if (w_rd) begin
        r_sel <= w_bank;
      end
    end
  end

  assign w_q = w_bank_q[r_sel];

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_v2;
      logic [DATA_W-1:0] r_d2;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= w_q;
          end
        end
      end

      assign rsp_valid = r_v2;
      assign rsp_rdata = r_d2;
    end else begin : g_lat1
      assign rsp_valid = r_v1;
      assign rsp_rdata = w_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_asic_sram_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_asic_sram_banked
// Purpose  : Self-checking bench for asic_sram_banked. It runs one RD_LAT=1
//            instance and one RD_LAT=2 instance from the same stimulus and
//            checks both against a word-array reference model with
//            per-latency response schedules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_asic_sram_banked;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  logic        ready1, busy1, rv1, ready2, busy2, rv2;
  logic [31:0] rd1, rd2;
  logic [1:0]  act1, act2;

  always #5 clk = ~clk;

  asic_sram_banked #(.DATA_W(32), .ADDR_W(6), .NUM_BANKS(2), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .init_busy(busy1), .bank_act(act1)
  );

  asic_sram_banked #(.DATA_W(32), .ADDR_W(6), .NUM_BANKS(2), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .init_busy(busy2), .bank_act(act2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a flat word array, the RUN/INIT flag and a count of
  // cleared words, plus a queue of scheduled responses for each latency.
  logic [31:0] m_mem [64];
  bit          m_run;
  int          m_cnt;
  int          edge_n;
  int          due1[$], due2[$];
  logic [31:0] dat1[$], dat2[$];
  logic        exp_v1, exp_v2;
  logic [31:0] exp_d1, exp_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int a);
    return (a % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    due1.delete(); due2.delete(); dat1.delete(); dat2.delete();
    exp_d1 = '0;
    exp_d2 = '0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model across the edge, then check the response outputs.
  task automatic step(input bit r, input bit v, input bit we, input int a,
                      input logic [3:0] be, input logic [31:0] wd);
    logic [1:0] exp_act;
    rst_n = r; req_valid = v; req_we = we; req_addr = 6'(a);
    req_be = be; req_wdata = wd;
    #1;
    if (!r)           exp_act = 2'b00;
    else if (!m_run)  exp_act = onehot(m_cnt);
    else if (v)       exp_act = onehot(a);
    else              exp_act = 2'b00;
    check("bank_act1", 32'(act1), 32'(exp_act));
    check("bank_act2", 32'(act2), 32'(exp_act));
    check("req_ready1", 32'(ready1), 32'(m_run));
    check("req_ready2", 32'(ready2), 32'(m_run));
    check("init_busy1", 32'(busy1), 32'(!m_run));
    check("init_busy2", 32'(busy2), 32'(!m_run));

    @(posedge clk);
    edge_n++;
    if (!r) begin
      model_reset();
    end else if (!m_run) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 63) m_run = 1'b1;
      m_cnt = (m_cnt + 1) % 64;
    end else if (v) begin
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) m_mem[a][8*k +: 8] = wd[8*k +: 8];
      end else begin
        due1.push_back(edge_n);     dat1.push_back(m_mem[a]);
        due2.push_back(edge_n + 1); dat2.push_back(m_mem[a]);
      end
    end
    exp_v1 = 1'b0;
    if (due1.size() > 0 && due1[0] == edge_n) begin
      exp_v1 = 1'b1; exp_d1 = dat1[0];
      void'(due1.pop_front()); void'(dat1.pop_front());
    end
    exp_v2 = 1'b0;
    if (due2.size() > 0 && due2[0] == edge_n) begin
      exp_v2 = 1'b1; exp_d2 = dat2[0];
      void'(due2.pop_front()); void'(dat2.pop_front());
    end

    @(negedge clk);
    check("rsp_valid1", 32'(rv1), 32'(exp_v1));
    check("rsp_rdata1", rd1, exp_d1);
    check("rsp_valid2", 32'(rv2), 32'(exp_v2));
    check("rsp_rdata2", rd2, exp_d2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
  endtask

  task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b1, a, be, d);
  endtask

  task automatic rd(input int a);
    step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  initial begin
    edge_n = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset held, then INIT with requests hammering the port (must be ignored).
    step(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 66; i++)
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
           4'($urandom), $urandom);
    for (int a = 0; a < 4; a++) rd(a * 17 % 64);
    idle(2);

    // Byte-lane merge.
    wr(5, 4'hF, 32'hAABBCCDD);
    wr(5, 4'h5, 32'h11223344);
    rd(5);
    idle(3);

    // Bank isolation and all-zero byte-enable write.
    wr(4, 4'hF, 32'hCAFE0004);
    wr(7, 4'hF, 32'hBEEF0007);
    wr(4, 4'h0, 32'hFFFFFFFF);
    rd(4);
    rd(7);
    idle(3);

    // Back-to-back reads.
    for (int a = 0; a < 4; a++) wr(a, 4'hF, 32'h1000_0000 + 32'(a));
    for (int a = 0; a < 4; a++) rd(a);
    idle(3);

    // Reset on the cycle after a read; sweep must repeat and clear address 5.
    wr(5, 4'hF, 32'h5555AAAA);
    rd(5);
    step(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(66);
    rd(5);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
      else
        step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 63)), 4'($urandom), $urandom);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
